free_rsp_merger: RTL and testbench

//  Merges the two producers of free responses into the single free-rsp FIFO write port.

---
 rtl/free_rsp_merger.sv | 142 ++++++++++++++
 tb/tb_free_rsp_merger.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/free_rsp_merger.sv
// Merges dispatcher fail responses and or_tree completion responses into the single
// free-rsp FIFO write port, with a small per-source queue and round-robin drain.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 3
`endif
`ifndef FREE_FAIL_REASON_EQUAL_ZERO
`define FREE_FAIL_REASON_EQUAL_ZERO 3'd1
`endif

module free_rsp_merger #(
  parameter int QDEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          disp_rsp_write_en,
  input  logic [`REQ_ID_WIDTH-1:0]      disp_rsp_id,
  input  logic                          disp_rsp_fail,
  input  logic [`FAIL_REASON_WIDTH-1:0] disp_rsp_fail_reason,
  input  logic                          tree_rsp_valid,
  input  logic [`REQ_ID_WIDTH-1:0]      tree_rsp_id,
  input  logic                          tree_rsp_fail,
  input  logic [`FAIL_REASON_WIDTH-1:0] tree_rsp_fail_reason,
  input  logic                          rsp_fifo_full,
  input  logic                          rsp_fifo_almost_full,
  output logic                          rsp_fifo_write_en,
  output logic [`REQ_ID_WIDTH-1:0]      rsp_fifo_id,
  output logic                          rsp_fifo_fail,
  output logic [`FAIL_REASON_WIDTH-1:0] rsp_fifo_fail_reason,
  output logic                          rsp_almost_full_out,
  output logic                          overflow_err
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [`REQ_ID_WIDTH-1:0]      id;
    logic                          fail;
    logic [`FAIL_REASON_WIDTH-1:0] reason;
  } rsp_t;

  typedef enum logic {SRC_DISP = 1'b0, SRC_TREE = 1'b1} src_e;

  rsp_t            mem     [2][QDEPTH];
  logic [AW-1:0]   rd_ptr  [2];
  logic [AW-1:0]   wr_ptr  [2];
  logic [CW-1:0]   count   [2];
  rsp_t            push_data [2];
  logic [1:0]      push;
  logic [1:0]      accept;
  logic [1:0]      pop;
  logic [1:0]      not_empty;
  src_e            prio, prio_next;
  rsp_t            pop_data;

  assign push         = {tree_rsp_valid, disp_rsp_write_en};
  assign push_data[0] = '{disp_rsp_id, disp_rsp_fail, disp_rsp_fail_reason};
  assign push_data[1] = '{tree_rsp_id, tree_rsp_fail, tree_rsp_fail_reason};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      not_empty[i] = (count[i] != '0);
      // A full queue still takes a push when it is being popped in the same cycle.
      accept[i]    = push[i] && ((count[i] != CW'(QDEPTH)) || pop[i]);
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pop       = 2'b00;
    prio_next = prio;
    if (!rsp_fifo_full) begin
      if (not_empty[0] && not_empty[1]) begin
        if (prio == SRC_DISP) begin
          pop[0]    = 1'b1;
          prio_next = SRC_TREE;
        end else begin
          pop[1]    = 1'b1;
          prio_next = SRC_DISP;
        end
      end else if (not_empty[0]) begin
        pop[0] = 1'b1;
      end else if (not_empty[1]) begin
        pop[1] = 1'b1;
      end
    end
  end

  assign pop_data = pop[1] ? mem[1][rd_ptr[1]] : mem[0][rd_ptr[0]];

  // NOTE: queue storage is not reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) mem[i][wr_ptr[i]] <= push_data[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      prio         <= SRC_DISP;
      overflow_err <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])    rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i] <= count[i] + CW'(accept[i]) - CW'(pop[i]);
        if (push[i] && !accept[i]) overflow_err <= 1'b1;
      end
      prio <= prio_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_fifo_write_en    <= 1'b0;
      rsp_fifo_id          <= '0;
      rsp_fifo_fail        <= 1'b0;
      rsp_fifo_fail_reason <= '0;
    end else begin
      rsp_fifo_write_en <= |pop;
      if (|pop) begin
        rsp_fifo_id          <= pop_data.id;
        rsp_fifo_fail        <= pop_data.fail;
        rsp_fifo_fail_reason <= pop_data.reason;
      end
    end
  end

  assign rsp_almost_full_out = rsp_fifo_almost_full
                            || (count[0] >= CW'(QDEPTH - 1))
                            || (count[1] >= CW'(QDEPTH - 1));

endmodule

// File: tb/tb_free_rsp_merger.sv
// Directed bench for free_rsp_merger: stimulus pushes expected writes into a queue,
// an independent monitor pops and compares each FIFO write.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 3
`endif
`ifndef FREE_FAIL_REASON_EQUAL_ZERO
`define FREE_FAIL_REASON_EQUAL_ZERO 3'd1
`endif

module tb_free_rsp_merger;

  typedef struct packed {
    logic [`REQ_ID_WIDTH-1:0]      id;
    logic                          fail;
    logic [`FAIL_REASON_WIDTH-1:0] reason;
  } exp_t;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          disp_rsp_write_en;
  logic [`REQ_ID_WIDTH-1:0]      disp_rsp_id;
  logic                          disp_rsp_fail;
  logic [`FAIL_REASON_WIDTH-1:0] disp_rsp_fail_reason;
  logic                          tree_rsp_valid;
  logic [`REQ_ID_WIDTH-1:0]      tree_rsp_id;
  logic                          tree_rsp_fail;
  logic [`FAIL_REASON_WIDTH-1:0] tree_rsp_fail_reason;
  logic                          rsp_fifo_full;
  logic                          rsp_fifo_almost_full;
  logic                          rsp_fifo_write_en;
  logic [`REQ_ID_WIDTH-1:0]      rsp_fifo_id;
  logic                          rsp_fifo_fail;
  logic [`FAIL_REASON_WIDTH-1:0] rsp_fifo_fail_reason;
  logic                          rsp_almost_full_out;
  logic                          overflow_err;

  int   vectors    = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  free_rsp_merger #(.QDEPTH(4)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .disp_rsp_write_en    (disp_rsp_write_en),
    .disp_rsp_id          (disp_rsp_id),
    .disp_rsp_fail        (disp_rsp_fail),
    .disp_rsp_fail_reason (disp_rsp_fail_reason),
    .tree_rsp_valid       (tree_rsp_valid),
    .tree_rsp_id          (tree_rsp_id),
    .tree_rsp_fail        (tree_rsp_fail),
    .tree_rsp_fail_reason (tree_rsp_fail_reason),
    .rsp_fifo_full        (rsp_fifo_full),
    .rsp_fifo_almost_full (rsp_fifo_almost_full),
    .rsp_fifo_write_en    (rsp_fifo_write_en),
    .rsp_fifo_id          (rsp_fifo_id),
    .rsp_fifo_fail        (rsp_fifo_fail),
    .rsp_fifo_fail_reason (rsp_fifo_fail_reason),
    .rsp_almost_full_out  (rsp_almost_full_out),
    .overflow_err         (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    disp_rsp_write_en = 1'b0;
    tree_rsp_valid    = 1'b0;
  endtask

  task automatic set_disp(input logic [7:0] id, input logic fail, input logic [2:0] reason);
    disp_rsp_write_en    = 1'b1;
    disp_rsp_id          = id;
    disp_rsp_fail        = fail;
    disp_rsp_fail_reason = reason;
  endtask

  task automatic set_tree(input logic [7:0] id, input logic fail, input logic [2:0] reason);
    tree_rsp_valid       = 1'b1;
    tree_rsp_id          = id;
    tree_rsp_fail        = fail;
    tree_rsp_fail_reason = reason;
  endtask

  task automatic expect_wr(input logic [7:0] id, input logic fail, input logic [2:0] reason);
    exp_q.push_back('{id, fail, reason});
  endtask

  // Wait until every expected write has been seen, then allow a few idle cycles.
  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout_pending", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  // Monitor: compares every FIFO write against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_fifo_write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_id", {24'd0, rsp_fifo_id}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_id", {24'd0, rsp_fifo_id}, {24'd0, e.id});
          check("wr_fail", {31'd0, rsp_fifo_fail}, {31'd0, e.fail});
          check("wr_reason", {29'd0, rsp_fifo_fail_reason}, {29'd0, e.reason});
        end
      end
    end
  end

  initial begin
    rst_n                = 1'b0;
    disp_rsp_write_en    = 1'b0;
    disp_rsp_id          = '0;
    disp_rsp_fail        = 1'b0;
    disp_rsp_fail_reason = '0;
    tree_rsp_valid       = 1'b0;
    tree_rsp_id          = '0;
    tree_rsp_fail        = 1'b0;
    tree_rsp_fail_reason = '0;
    rsp_fifo_full        = 1'b0;
    rsp_fifo_almost_full = 1'b0;
    #12;
    check("reset_write_en", {31'd0, rsp_fifo_write_en}, 0);
    check("reset_data", {20'd0, rsp_fifo_id, rsp_fifo_fail, rsp_fifo_fail_reason}, 0);
    check("reset_almost_full", {31'd0, rsp_almost_full_out}, 0);
    check("reset_overflow", {31'd0, overflow_err}, 0);
    rst_n = 1'b1;
    tick();

    // 1: single disp pulse, write two edges later for exactly one cycle.
    expect_wr(8'd5, 1'b1, `FREE_FAIL_REASON_EQUAL_ZERO);
    set_disp(8'd5, 1'b1, `FREE_FAIL_REASON_EQUAL_ZERO);
    tick();
    clear_inputs();
    check("t1_we_after_sample", {31'd0, rsp_fifo_write_en}, 0);
    tick();
    check("t1_we_next", {31'd0, rsp_fifo_write_en}, 1);
    tick();
    check("t1_we_one_cycle", {31'd0, rsp_fifo_write_en}, 0);
    drain(20);

    // Almost-full input is passed straight through.
    rsp_fifo_almost_full = 1'b1;
    #1 check("af_passthrough", {31'd0, rsp_almost_full_out}, 1);
    rsp_fifo_almost_full = 1'b0;
    #1 check("af_passthrough_off", {31'd0, rsp_almost_full_out}, 0);

    // 2: two simultaneous pairs, round-robin gives 1,2,3,4.
    expect_wr(8'd1, 1'b1, 3'd2);
    expect_wr(8'd2, 1'b0, 3'd0);
    expect_wr(8'd3, 1'b1, 3'd3);
    expect_wr(8'd4, 1'b0, 3'd5);
    set_disp(8'd1, 1'b1, 3'd2);
    set_tree(8'd2, 1'b0, 3'd0);
    tick();
    set_disp(8'd3, 1'b1, 3'd3);
    set_tree(8'd4, 1'b0, 3'd5);
    tick();
    clear_inputs();
    drain(20);

    // 3: FIFO full holds three tree entries; almost-full once count reaches 3.
    rsp_fifo_full = 1'b1;
    set_tree(8'd7, 1'b0, 3'd1); tick();
    clear_inputs();
    check("t3_af_count1", {31'd0, rsp_almost_full_out}, 0);
    set_tree(8'd8, 1'b1, 3'd2); tick();
    set_tree(8'd9, 1'b0, 3'd3); tick();
    clear_inputs();
    check("t3_af_count3", {31'd0, rsp_almost_full_out}, 1);
    tick();
    check("t3_no_write_while_full", {31'd0, rsp_fifo_write_en}, 0);
    expect_wr(8'd7, 1'b0, 3'd1);
    expect_wr(8'd8, 1'b1, 3'd2);
    expect_wr(8'd9, 1'b0, 3'd3);
    rsp_fifo_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_back_to_back_we", {31'd0, rsp_fifo_write_en}, 1);
    end
    tick();
    check("t3_we_after_drain", {31'd0, rsp_fifo_write_en}, 0);
    check("t3_af_after_drain", {31'd0, rsp_almost_full_out}, 0);
    drain(20);

    // 5: full queue with simultaneous push and pop keeps all entries, no overflow.
    rsp_fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_tree(8'(20 + i), 1'b1, 3'(i));
      expect_wr(8'(20 + i), 1'b1, 3'(i));
      tick();
    end
    clear_inputs();
    check("t5_af_full_queue", {31'd0, rsp_almost_full_out}, 1);
    rsp_fifo_full = 1'b0;
    set_tree(8'd24, 1'b0, 3'd7);
    expect_wr(8'd24, 1'b0, 3'd7);
    tick();
    clear_inputs();
    check("t5_no_overflow", {31'd0, overflow_err}, 0);
    drain(20);
    check("t5_no_overflow_after", {31'd0, overflow_err}, 0);

    // 4: fifth push into a full queue is dropped, overflow is sticky.
    rsp_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_tree(8'(10 + i), 1'b0, 3'd4);
      if (i < 4) expect_wr(8'(10 + i), 1'b0, 3'd4);
      tick();
    end
    clear_inputs();
    check("t4_overflow_set", {31'd0, overflow_err}, 1);
    rsp_fifo_full = 1'b0;
    drain(20);
    check("t4_overflow_sticky", {31'd0, overflow_err}, 1);

    // 6: reset with two entries queued discards them and clears everything.
    rsp_fifo_full = 1'b1;
    set_disp(8'd30, 1'b1, 3'd6); tick();
    set_disp(8'd31, 1'b0, 3'd2); tick();
    clear_inputs();
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_write_en", {31'd0, rsp_fifo_write_en}, 0);
    check("t6_rst_data", {20'd0, rsp_fifo_id, rsp_fifo_fail, rsp_fifo_fail_reason}, 0);
    check("t6_rst_overflow", {31'd0, overflow_err}, 0);
    check("t6_rst_almost_full", {31'd0, rsp_almost_full_out}, 0);
    rsp_fifo_full = 1'b0;
    #2 rst_n = 1'b1;
    repeat (6) tick();
    check("t6_overflow_after", {31'd0, overflow_err}, 0);
    check("t6_no_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
